// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN window sequencing controller.
package cnn_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_delay_line.sv
// Single-bit shift delay of DEPTH cycles with asynchronous clear.
module cnn_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sr <= '0;
        else     sr <= din;
      end
    end else begin : g_multi
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sr <= '0;
        else     sr <= {sr[DEPTH-2:0], din};
      end
    end
  endgenerate

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/cnn_seq_ctrl.sv
// Frame sequencer feeding a KxK convolution datapath from a pixel stream.
// Optional CNN_CTRL_PERF_EN adds a saturating frame_cycles performance counter.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start
// ST_CLEAR  | one-cycle datapath clear, row/col counters zeroed
// ST_STREAM | accepting pixels until the last pixel of the frame
// ST_DRAIN  | PIPE_LAT+1 cycles letting the datapath flush its results
// ST_DONE   | one-cycle end-of-frame pulse
module cnn_seq_ctrl
  import cnn_pkg::*;
#(
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8,
  parameter int K        = 3,
  parameter int PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_in,
  output logic             pix_ready,
  output logic             dp_clear,
  output logic [PIX_W-1:0] dp_pixel,
  output logic             dp_shift,
  output logic             dp_win_valid,
  output logic             res_valid,
  output logic             busy,
  output logic             done
`ifdef CNN_CTRL_PERF_EN
  ,
  output logic [15:0]      frame_cycles
`endif
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam int DW = cnt_w(PIPE_LAT + 1);

  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_WIN    = CW'(K - 1);
  localparam logic [RW-1:0] ROW_WIN    = RW'(K - 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(PIPE_LAT);

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [DW-1:0] drain_cnt;
  logic          accept;
  logic          last_pix;
  logic          win_pix;

  assign pix_ready = (state == ST_STREAM);
  assign accept    = pix_valid & pix_ready;
  assign last_pix  = (row == ROW_LAST) && (col == COL_LAST);
  assign win_pix   = (row >= ROW_WIN) && (col >= COL_WIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      col          <= '0;
      row          <= '0;
      drain_cnt    <= '0;
      dp_clear     <= 1'b0;
      dp_pixel     <= '0;
      dp_shift     <= 1'b0;
      dp_win_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      dp_clear     <= 1'b0;
      done         <= 1'b0;
      dp_shift     <= accept;
      dp_win_valid <= accept && win_pix;
      if (accept) dp_pixel <= pix_in;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_CLEAR;
            dp_clear <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state <= ST_STREAM;
          col   <= '0;
          row   <= '0;
        end
        ST_STREAM: begin
          if (accept) begin
            if (col == COL_LAST) begin
              col <= '0;
              row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (last_pix) begin
              state     <= ST_DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  cnn_delay_line #(
    .DEPTH(PIPE_LAT)
  ) u_res_dly (
    .clk (clk),
    .rst (rst),
    .din (dp_win_valid),
    .dout(res_valid)
  );

`ifdef CNN_CTRL_PERF_EN
  logic [15:0] cyc_cnt;
  logic [15:0] cyc_next;

  assign cyc_next = (cyc_cnt == 16'hFFFF) ? cyc_cnt : cyc_cnt + 16'd1;

  // The value latched on the last drain edge includes that final drain cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt      <= '0;
      frame_cycles <= '0;
    end else begin
      case (state)
        ST_CLEAR:  cyc_cnt <= 16'd1;
        ST_STREAM: cyc_cnt <= cyc_next;
        ST_DRAIN: begin
          cyc_cnt <= cyc_next;
          if (drain_cnt == '0) frame_cycles <= cyc_next;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_cnn_seq_ctrl.sv
// Bench for cnn_seq_ctrl on a 4x4 image, 3x3 window, two-cycle datapath latency.
module tb_cnn_seq_ctrl;

  localparam int W   = 4;
  localparam int H   = 4;
  localparam int K   = 3;
  localparam int LAT = 2;
  localparam int N   = W * H;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       pix_valid;
  logic [7:0] pix_in;
  logic       pix_ready;
  logic       dp_clear;
  logic [7:0] dp_pixel;
  logic       dp_shift;
  logic       dp_win_valid;
  logic       res_valid;
  logic       busy;
  logic       done;
`ifdef CNN_CTRL_PERF_EN
  logic [15:0] frame_cycles;
`endif

  cnn_seq_ctrl #(
    .IMG_W(W), .IMG_H(H), .K(K), .PIPE_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_in(pix_in),
    .pix_ready(pix_ready), .dp_clear(dp_clear), .dp_pixel(dp_pixel),
    .dp_shift(dp_shift), .dp_win_valid(dp_win_valid), .res_valid(res_valid),
    .busy(busy), .done(done)
`ifdef CNN_CTRL_PERF_EN
    , .frame_cycles(frame_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Observed and expected event logs; shift/window entries pack cycle*256 + pixel.
  int o_clr[$], o_rdy[$], o_shift[$], o_win[$], o_res[$], o_done[$], o_fc[$];
  int e_clr[$], e_rdy[$], e_shift[$], e_win[$], e_res[$], e_done[$];
  int o_busy_n, e_busy_n, e_fc;
  string cat[6] = '{"clear", "ready", "shift", "win", "res", "done"};

  always @(negedge clk) begin
    if (!rst) begin
      if (dp_clear)     o_clr.push_back(cyc);
      if (pix_ready)    o_rdy.push_back(cyc);
      if (dp_shift)     o_shift.push_back(cyc * 256 + int'(dp_pixel));
      if (dp_win_valid) o_win.push_back(cyc * 256 + int'(dp_pixel));
      if (res_valid)    o_res.push_back(cyc);
      if (done)         o_done.push_back(cyc);
      if (busy)         o_busy_n++;
`ifdef CNN_CTRL_PERF_EN
      if (done)         o_fc.push_back(int'(frame_cycles));
`endif
    end
  end

  function automatic int unsigned sig(input int q[$]);
    int unsigned s;
    s = 32'h1234 ^ q.size();
    foreach (q[i]) s = (s * 32'd33) ^ q[i];
    return s;
  endfunction

  // Drives one frame starting this cycle and predicts every event from the
  // raster position of each accepted pixel.  mode 0: always valid, pixels
  // 1..N; mode 1: valid every other cycle; mode 2: random valid.
  task automatic run_frame(input int mode, input bit hold_start, input int max_acc);
    int c, n, last;
    bit in_stream;
    e_clr.delete(); e_rdy.delete(); e_shift.delete(); e_win.delete(); e_res.delete(); e_done.delete();
    o_clr.delete(); o_rdy.delete(); o_shift.delete(); o_win.delete(); o_res.delete(); o_done.delete();
    o_fc.delete(); o_busy_n = 0;
    c = cyc; n = 0; last = 0;
    e_clr.push_back(c + 1);
    forever begin
      in_stream = (cyc >= c + 2) && (n < N);
      start = (cyc == c) || (hold_start && n < N);
      if (n >= N)         pix_valid = 1'b1;
      else if (mode == 0) pix_valid = 1'b1;
      else if (mode == 1) pix_valid = ((cyc - c) % 2 == 0);
      else                pix_valid = ($urandom_range(0, 3) != 0);
      pix_in = (mode == 0) ? 8'(n + 1) : 8'($urandom_range(0, 255));
      if (in_stream) e_rdy.push_back(cyc);
      if (in_stream && pix_valid) begin
        e_shift.push_back((cyc + 1) * 256 + int'(pix_in));
        if ((n / W) >= K - 1 && (n % W) >= K - 1) begin
          e_win.push_back((cyc + 1) * 256 + int'(pix_in));
          e_res.push_back(cyc + 1 + LAT);
        end
        n++;
        if (n == N) last = cyc;
      end
      @(posedge clk); #1;
      if (max_acc < N && n == max_acc) return;
      if (n == N && cyc == last + LAT + 3) break;
      if (cyc - c > 4000) break;
    end
    start = 1'b0;
    pix_valid = 1'b0;
    e_done.push_back(last + LAT + 2);
    e_busy_n = last + LAT + 2 - c;
    e_fc = last - c + LAT + 1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({pix_ready, dp_clear, dp_shift, dp_win_valid, res_valid, busy, done} !== 7'b0 || dp_pixel !== 8'd0) begin
      failures++;
      $display("FAIL reset.outputs: got ctl=%b pix=%0d, want ctl=0 pix=0",
               {pix_ready, dp_clear, dp_shift, dp_win_valid, res_valid, busy, done}, dp_pixel);
    end
    rst = 1'b0;
    o_clr.delete(); o_rdy.delete(); o_shift.delete(); o_done.delete(); o_busy_n = 0;
    pix_valid = 1'b1; pix_in = 8'hA5;
    repeat (6) @(posedge clk);
    #1;
    pix_valid = 1'b0;
    checks++;
    if (o_clr.size() + o_rdy.size() + o_shift.size() + o_done.size() + o_busy_n != 0) begin
      failures++;
      $display("FAIL reset.idle_valid: got clr=%0d rdy=%0d shift=%0d done=%0d busy=%0d, want all 0",
               o_clr.size(), o_rdy.size(), o_shift.size(), o_done.size(), o_busy_n);
    end
  endtask

  task automatic test_back_to_back;
    int unsigned got[6], want[6];
    run_frame(0, 0, N);
    got  = '{sig(o_clr), sig(o_rdy), sig(o_shift), sig(o_win), sig(o_res), sig(o_done)};
    want = '{sig(e_clr), sig(e_rdy), sig(e_shift), sig(e_win), sig(e_res), sig(e_done)};
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got[i] !== want[i]) begin
        failures++;
        $display("FAIL b2b.%s: got sig=%08h, want sig=%08h", cat[i], got[i], want[i]);
      end
    end
    checks++;
    if (o_win.size() != 4 || (o_win[0] & 255) != 11 || (o_win[1] & 255) != 12 ||
        (o_win[2] & 255) != 15 || (o_win[3] & 255) != 16) begin
      failures++;
      $display("FAIL b2b.win_pixels: got n=%0d first=%0d last=%0d, want 11,12,15,16",
               o_win.size(), o_win.size() > 0 ? o_win[0] & 255 : -1,
               o_win.size() > 0 ? o_win[o_win.size()-1] & 255 : -1);
    end
    checks++;
    if (o_busy_n != e_busy_n) begin
      failures++;
      $display("FAIL b2b.busy_cycles: got %0d, want %0d", o_busy_n, e_busy_n);
    end
    checks++;
    if (dp_pixel !== 8'd16 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b.hold: got dp_pixel=%0d busy=%b, want 16 0", dp_pixel, busy);
    end
`ifdef CNN_CTRL_PERF_EN
    checks++;
    if (o_fc.size() != 1 || o_fc[0] != 20) begin
      failures++;
      $display("FAIL b2b.frame_cycles: got n=%0d val=%0d, want 20", o_fc.size(),
               o_fc.size() > 0 ? o_fc[0] : -1);
    end
`endif
  endtask

  task automatic test_stall;
    int unsigned got[6], want[6];
    run_frame(1, 0, N);
    got  = '{sig(o_clr), sig(o_rdy), sig(o_shift), sig(o_win), sig(o_res), sig(o_done)};
    want = '{sig(e_clr), sig(e_rdy), sig(e_shift), sig(e_win), sig(e_res), sig(e_done)};
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got[i] !== want[i]) begin
        failures++;
        $display("FAIL stall.%s: got sig=%08h, want sig=%08h", cat[i], got[i], want[i]);
      end
    end
    checks++;
    if (int'(dp_pixel) != (e_shift[e_shift.size()-1] & 255)) begin
      failures++;
      $display("FAIL stall.pixel_hold: got %0d, want %0d", dp_pixel, e_shift[e_shift.size()-1] & 255);
    end
`ifdef CNN_CTRL_PERF_EN
    checks++;
    if (o_fc.size() != 1 || o_fc[0] != e_fc) begin
      failures++;
      $display("FAIL stall.frame_cycles: got %0d, want %0d", o_fc.size() > 0 ? o_fc[0] : -1, e_fc);
    end
`endif
  endtask

  task automatic test_start_ignored;
    int unsigned got[6], want[6];
    run_frame(2, 1, N);
    got  = '{sig(o_clr), sig(o_rdy), sig(o_shift), sig(o_win), sig(o_res), sig(o_done)};
    want = '{sig(e_clr), sig(e_rdy), sig(e_shift), sig(e_win), sig(e_res), sig(e_done)};
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got[i] !== want[i]) begin
        failures++;
        $display("FAIL start_ign.%s: got sig=%08h, want sig=%08h", cat[i], got[i], want[i]);
      end
    end
    checks++;
    if (o_res.size() != 4 || o_busy_n != e_busy_n) begin
      failures++;
      $display("FAIL start_ign.count: got res=%0d busy=%0d, want res=4 busy=%0d",
               o_res.size(), o_busy_n, e_busy_n);
    end
  endtask

  task automatic test_mid_reset;
    int unsigned got[6], want[6];
    run_frame(0, 0, 7);
    checks++;
    if (dp_shift !== 1'b1 || dp_pixel !== 8'd7) begin
      failures++;
      $display("FAIL midrst.pre: got shift=%b pix=%0d, want 1 7", dp_shift, dp_pixel);
    end
    rst = 1'b1; pix_valid = 1'b0; start = 1'b0;
    #1;
    checks++;
    if ({pix_ready, dp_clear, dp_shift, dp_win_valid, res_valid, busy, done} !== 7'b0 || dp_pixel !== 8'd0) begin
      failures++;
      $display("FAIL midrst.async: got ctl=%b pix=%0d, want ctl=0 pix=0",
               {pix_ready, dp_clear, dp_shift, dp_win_valid, res_valid, busy, done}, dp_pixel);
    end
    o_rdy.delete(); o_shift.delete(); o_res.delete(); o_done.delete(); o_busy_n = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; pix_valid = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    pix_valid = 1'b0;
    checks++;
    if (o_rdy.size() + o_shift.size() + o_res.size() + o_done.size() + o_busy_n != 0) begin
      failures++;
      $display("FAIL midrst.idle: got rdy=%0d shift=%0d res=%0d done=%0d busy=%0d, want all 0",
               o_rdy.size(), o_shift.size(), o_res.size(), o_done.size(), o_busy_n);
    end
    run_frame(2, 0, N);
    got  = '{sig(o_clr), sig(o_rdy), sig(o_shift), sig(o_win), sig(o_res), sig(o_done)};
    want = '{sig(e_clr), sig(e_rdy), sig(e_shift), sig(e_win), sig(e_res), sig(e_done)};
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got[i] !== want[i]) begin
        failures++;
        $display("FAIL midrst.%s: got sig=%08h, want sig=%08h", cat[i], got[i], want[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
